// File: rtl/key_event_if.sv
// key_event_if: note-event stream from key_event_capture to the note-matching stage.
// An event transfers on a clock edge where event_valid && event_ready; while event_valid
// is high and event_ready is low the producer holds all event fields stable.
interface key_event_if;
  logic       event_valid;
  logic       event_ready;
  logic [3:0] event_note;
  logic [1:0] event_octave;
  logic       event_release;

  modport master (
    output event_valid, event_note, event_octave, event_release,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_note, event_octave, event_release,
    output event_ready
  );
endinterface

// File: rtl/key_event_capture.sv
// key_event_capture: synchronises and debounces note keys and emits one note event per press.
// Define KEY_RELEASE_EVENT_EN to also emit release events (event_release=1).
module key_event_capture #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [1:0]          octave_keys,
  input  logic                clear_overrun,
  output logic [3:0]          held_note,
  output logic                overrun,
  key_event_if.master         evt
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] key_s1, key_s2, stable, stable_d;
  logic [1:0]          oct_s1, oct_s2;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];

  logic [NUM_KEYS-1:0] press;
  logic                new_evt;
  logic [3:0]          new_note, held_next;

  logic                ev_valid;
  logic [3:0]          ev_note;
  logic [1:0]          ev_oct;

`ifdef KEY_RELEASE_EVENT_EN
  logic [NUM_KEYS-1:0] rel_edge;
  logic                new_rel, ev_rel;
  assign rel_edge = stable_d & ~stable;
`endif

  // Lowest key index wins among simultaneous edges; presses outrank releases.
  always_comb begin
    press    = stable & ~stable_d;
    new_evt  = 1'b0;
    new_note = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) begin
        new_evt  = 1'b1;
        new_note = 4'(i + 1);
      end
    end
`ifdef KEY_RELEASE_EVENT_EN
    new_rel = 1'b0;
    if (!new_evt) begin
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
        if (rel_edge[i]) begin
          new_evt  = 1'b1;
          new_rel  = 1'b1;
          new_note = 4'(i + 1);
        end
      end
    end
`endif
    held_next = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (stable[i]) held_next = 4'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1   <= '0;
      key_s2   <= '0;
      oct_s1   <= '0;
      oct_s2   <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      key_s1   <= key_in;
      key_s2   <= key_s1;
      oct_s1   <= octave_keys;
      oct_s2   <= oct_s1;
      stable_d <= stable;
      // A change must persist for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts it.
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= key_s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_valid  <= 1'b0;
      ev_note   <= '0;
      ev_oct    <= '0;
      held_note <= '0;
      overrun   <= 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
      ev_rel    <= 1'b0;
`endif
    end else begin
      held_note <= held_next;
      if (!ev_valid || evt.event_ready) begin
        ev_valid <= new_evt;
        if (new_evt) begin
          ev_note <= new_note;
          ev_oct  <= oct_s2;
`ifdef KEY_RELEASE_EVENT_EN
          ev_rel  <= new_rel;
`endif
        end
      end
      // A drop wins over a simultaneous clear.
      if (ev_valid && !evt.event_ready && new_evt) overrun <= 1'b1;
      else if (clear_overrun)                      overrun <= 1'b0;
    end
  end

  assign evt.event_valid  = ev_valid;
  assign evt.event_note   = ev_note;
  assign evt.event_octave = ev_oct;
`ifdef KEY_RELEASE_EVENT_EN
  assign evt.event_release = ev_rel;
`else
  assign evt.event_release = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_capture.sv
// tb_key_event_capture: directed bench for key_event_capture with a cycle model and literal checks.
module tb_key_event_capture;
  localparam int DB = 4;

  logic       clk;
  logic       reset;
  logic [6:0] key_in;
  logic [1:0] octave_keys;
  logic       clear_overrun;
  logic [3:0] held_note;
  logic       overrun;

  key_event_if evt();

  key_event_capture #(.NUM_KEYS(7), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_in        (key_in),
    .octave_keys   (octave_keys),
    .clear_overrun (clear_overrun),
    .held_note     (held_note),
    .overrun       (overrun),
    .evt           (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: keys seen two edges late; a key's level is accepted after it
  // has differed from the accepted level for DB edges in a row; an accepted change produces
  // an event offered to the one-deep buffer on the following edge.
  logic [6:0] m_s1, m_s2, m_st, m_up, m_dn, m_old;
  logic [1:0] m_o1, m_o2, m_oct;
  logic       m_valid, m_rel, m_over, m_pick_rel;
  logic [3:0] m_note, m_held, m_pick;
  int         m_run [7];

  function automatic logic [3:0] lowest(input logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_up = '0; m_dn = '0;
      m_o1 = '0; m_o2 = '0; m_oct = '0;
      m_valid = 0; m_rel = 0; m_over = 0; m_note = '0; m_held = '0;
      for (int i = 0; i < 7; i++) m_run[i] = 0;
    end else begin
      m_pick = lowest(m_up);
      m_pick_rel = 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
      if (m_pick == 0) begin
        m_pick = lowest(m_dn);
        m_pick_rel = (m_pick != 0);
      end
`endif
      if (m_valid && !evt.event_ready) begin
        if (m_pick != 0) m_over = 1'b1;
        else if (clear_overrun) m_over = 1'b0;
      end else begin
        if (clear_overrun) m_over = 1'b0;
        m_valid = (m_pick != 0);
        if (m_pick != 0) begin
          m_note = m_pick;
          m_oct  = m_o2;
          m_rel  = m_pick_rel;
        end
      end
      m_held = lowest(m_st);
      m_old = m_st;
      for (int i = 0; i < 7; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_st[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_up = m_st & ~m_old;
      m_dn = m_old & ~m_st;
      m_s2 = m_s1; m_s1 = key_in;
      m_o2 = m_o1; m_o1 = octave_keys;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid", {7'd0, evt.event_valid}, {7'd0, m_valid});
    chk("held_note", {4'd0, held_note}, {4'd0, m_held});
    chk("overrun", {7'd0, overrun}, {7'd0, m_over});
    if (m_valid) begin
      chk("event_note", {4'd0, evt.event_note}, {4'd0, m_note});
      chk("event_octave", {6'd0, evt.event_octave}, {6'd0, m_oct});
      chk("event_release", {7'd0, evt.event_release}, {7'd0, m_rel});
    end
  end

  // ---------------- stimulus
  int         ev_cnt;
  logic [3:0] last_note;
  logic [1:0] last_oct;

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (evt.event_valid) begin
        ev_cnt++;
        last_note = evt.event_note;
        last_oct  = evt.event_octave;
      end
    end
  endtask

  initial begin
    reset = 1'b0; key_in = '0; octave_keys = '0; clear_overrun = 1'b0;
    evt.event_ready = 1'b0;
    ev_cnt = 0; last_note = '0; last_oct = '0;
    #1;
    chk("rst_valid", {7'd0, evt.event_valid}, 8'd0);
    chk("rst_held", {4'd0, held_note}, 8'd0);
    chk("rst_overrun", {7'd0, overrun}, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_cycles(2);

    // 1: single press, event after 2 + DB + 1 edges, lasting one cycle with ready high
    @(negedge clk);
    evt.event_ready = 1'b1;
    key_in = 7'b0000100;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 6) chk("t1_not_yet", {7'd0, evt.event_valid}, 8'd0);
      if (c == 7) begin
        chk("t1_valid", {7'd0, evt.event_valid}, 8'd1);
        chk("t1_note", {4'd0, evt.event_note}, 8'd3);
      end
      if (c == 8) begin
        chk("t1_one_cycle", {7'd0, evt.event_valid}, 8'd0);
        chk("t1_held", {4'd0, held_note}, 8'd3);
      end
    end
    @(negedge clk); key_in = '0;
    run_cycles(10);
    chk("t1_held_off", {4'd0, held_note}, 8'd0);

    // 2: bouncing key never settles
    ev_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk); key_in = (j % 2 == 0) ? 7'b0000001 : 7'b0000000;
      run_cycles(2);
    end
    @(negedge clk); key_in = '0;
    run_cycles(10);
    chk("t2_no_event", 8'(ev_cnt), 8'd0);
    chk("t2_held", {4'd0, held_note}, 8'd0);

    // 3: simultaneous presses, lowest index wins
    ev_cnt = 0;
    @(negedge clk); key_in = 7'b0100010;
    run_cycles(12);
    chk("t3_one_event", 8'(ev_cnt), 8'd1);
    chk("t3_note", {4'd0, last_note}, 8'd2);
    chk("t3_held", {4'd0, held_note}, 8'd2);
    @(negedge clk); key_in = '0;
    run_cycles(10);

    // 4: full buffer drops the second press and sets overrun
    @(negedge clk); evt.event_ready = 1'b0; key_in = 7'b0000001;
    run_cycles(8);
    chk("t4_valid", {7'd0, evt.event_valid}, 8'd1);
    chk("t4_note", {4'd0, evt.event_note}, 8'd1);
    @(negedge clk); key_in = 7'b1000001;
    run_cycles(8);
    chk("t4_note_kept", {4'd0, evt.event_note}, 8'd1);
    chk("t4_overrun", {7'd0, overrun}, 8'd1);
    @(negedge clk); clear_overrun = 1'b1;
    run_cycles(1);
    @(negedge clk); clear_overrun = 1'b0;
    chk("t4_cleared", {7'd0, overrun}, 8'd0);
    @(negedge clk); key_in = 7'b0000001;
    run_cycles(8);
    // drop and clear on the same edge: overrun must stay set
    @(negedge clk); clear_overrun = 1'b1; key_in = 7'b1000001;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 6) chk("t4_pre_drop", {7'd0, overrun}, 8'd0);
      if (c == 7) chk("t4_set_wins", {7'd0, overrun}, 8'd1);
    end
    run_cycles(1);
    @(negedge clk); clear_overrun = 1'b0;
    chk("t4_clear_after", {7'd0, overrun}, 8'd0);
    evt.event_ready = 1'b1;
    run_cycles(1);
    chk("t4_drained", {7'd0, evt.event_valid}, 8'd0);
    @(negedge clk); key_in = '0;
    run_cycles(10);

    // 5: octave captured with the press
    ev_cnt = 0;
    @(negedge clk); octave_keys = 2'b10; key_in = 7'b0001000;
    run_cycles(10);
    chk("t5_one_event", 8'(ev_cnt), 8'd1);
    chk("t5_note", {4'd0, last_note}, 8'd4);
    chk("t5_octave", {6'd0, last_oct}, 8'd2);
    chk("t5_held", {4'd0, held_note}, 8'd4);

    // 6: asynchronous reset with a held event and a key mid-debounce
    @(negedge clk); evt.event_ready = 1'b0; key_in = '0;
    run_cycles(8);
`ifdef KEY_RELEASE_EVENT_EN
    chk("t6_rel_note", {4'd0, evt.event_note}, 8'd4);
    chk("t6_rel_flag", {7'd0, evt.event_release}, 8'd1);
`endif
    @(negedge clk); key_in = 7'b0000001;
    run_cycles(8);
    chk("t6_valid", {7'd0, evt.event_valid}, 8'd1);
    @(negedge clk); key_in = 7'b0100001;
    run_cycles(3);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", {7'd0, evt.event_valid}, 8'd0);
    chk("t6_rst_note", {4'd0, evt.event_note}, 8'd0);
    chk("t6_rst_octave", {6'd0, evt.event_octave}, 8'd0);
    chk("t6_rst_release", {7'd0, evt.event_release}, 8'd0);
    chk("t6_rst_held", {4'd0, held_note}, 8'd0);
    chk("t6_rst_overrun", {7'd0, overrun}, 8'd0);
    key_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ev_cnt = 0;
    run_cycles(12);
    chk("t6_no_stale", 8'(ev_cnt), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
